// File: rtl/axi_llc_arcane_xfer_gen.sv
// axi_llc_arcane_xfer_gen
// Command sequencer for the ARCANE descriptor generators. A single
// line-transfer command turns into one single-beat AR per line on the
// source side and one single-beat AW per line on the destination side.
// Both carry the alloc/writeback flag.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cmd_*                  command handshake and payload (sampled in IDLE only)
//   ar_*                   source-side single-beat read requests
//   aw_*                   destination-side single-beat write requests
//   busy_o                 command in progress
//   done_o                 one-cycle pulse when a command has completed
//
// Optional feature: define ARCANE_XFER_GEN_SKEW_LIMIT_EN to stop AR from
// running more than MaxSkew lines ahead of AW.
module axi_llc_arcane_xfer_gen #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AxiId     = 0,
    parameter int unsigned LineBytes = 64,
    parameter int unsigned DataBytes = 8,
    parameter int unsigned CntWidth  = 8,
    parameter int unsigned MaxSkew   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_src_addr_i,
    input  logic [AddrWidth-1:0] cmd_dst_addr_i,
    input  logic [CntWidth-1:0]  cmd_num_lines_i,
    input  logic                 cmd_alloc_i,
    output logic [AddrWidth-1:0] ar_addr_o,
    output logic [IdWidth-1:0]   ar_id_o,
    output logic [2:0]           ar_size_o,
    output logic                 ar_src_dst_o,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    output logic [AddrWidth-1:0] aw_addr_o,
    output logic [IdWidth-1:0]   aw_id_o,
    output logic [2:0]           aw_size_o,
    output logic                 aw_src_dst_o,
    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned LineShift = $clog2(LineBytes);
    localparam int unsigned SizeVal   = $clog2(DataBytes);
    localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(LineBytes - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0] src_base_q, src_base_d;
    logic [AddrWidth-1:0] dst_base_q, dst_base_d;
    logic [CntWidth-1:0]  num_q, num_d;
    logic                 alloc_q, alloc_d;
    logic [CntWidth-1:0]  ar_cnt_q, ar_cnt_d;
    logic [CntWidth-1:0]  aw_cnt_q, aw_cnt_d;
    logic                 ar_valid_q, ar_valid_d;
    logic                 aw_valid_q, aw_valid_d;
    logic [AddrWidth-1:0] ar_addr_q, ar_addr_d;
    logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cmd_ready_q, cmd_ready_d;

    logic                 cmd_hs_c;
    logic                 ar_fire_c, aw_fire_c;
    logic [CntWidth-1:0]  ar_cnt_nx_c, aw_cnt_nx_c;
    logic                 lines_done_c;
    logic                 skew_ok_c;

    // Handshakes and post-handshake counter values shared by both comb blocks
    always_comb begin
        cmd_hs_c     = cmd_valid_i & cmd_ready_q & (state_q == ST_IDLE);
        ar_fire_c    = ar_valid_q & ar_ready_i;
        aw_fire_c    = aw_valid_q & aw_ready_i;
        ar_cnt_nx_c  = ar_cnt_q + CntWidth'(ar_fire_c);
        aw_cnt_nx_c  = aw_cnt_q + CntWidth'(aw_fire_c);
        lines_done_c = (ar_cnt_nx_c == num_q) && (aw_cnt_nx_c == num_q);
    end

`ifdef ARCANE_XFER_GEN_SKEW_LIMIT_EN
    // AR may only be raised while it leads AW by fewer than MaxSkew lines;
    // a raised valid is kept by the hold term in the output logic.
    always_comb begin
        skew_ok_c = (ar_cnt_nx_c <= aw_cnt_nx_c) ||
                    (32'(ar_cnt_nx_c - aw_cnt_nx_c) < 32'(MaxSkew));
    end
`else
    // AR and AW progress independently
    logic unused_skew_c;
    always_comb begin
        skew_ok_c     = 1'b1;
        unused_skew_c = (MaxSkew == 0);
    end
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs_c) begin
                    state_d = (cmd_num_lines_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (lines_done_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        num_d      = num_q;
        alloc_d    = alloc_q;
        ar_cnt_d   = ar_cnt_q;
        aw_cnt_d   = aw_cnt_q;
        ar_valid_d = ar_valid_q;
        aw_valid_d = aw_valid_q;
        ar_addr_d  = ar_addr_q;
        aw_addr_d  = aw_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_hs_c) begin
                    src_base_d = cmd_src_addr_i & LineMask;
                    dst_base_d = cmd_dst_addr_i & LineMask;
                    num_d      = cmd_num_lines_i;
                    alloc_d    = cmd_alloc_i;
                    ar_cnt_d   = '0;
                    aw_cnt_d   = '0;
                    ar_valid_d = (cmd_num_lines_i != '0);
                    aw_valid_d = (cmd_num_lines_i != '0);
                    ar_addr_d  = cmd_src_addr_i & LineMask;
                    aw_addr_d  = cmd_dst_addr_i & LineMask;
                end
            end
            ST_ISSUE: begin
                ar_cnt_d   = ar_cnt_nx_c;
                aw_cnt_d   = aw_cnt_nx_c;
                // A stalled request holds; otherwise raise the next line if any remain
                ar_valid_d = (ar_valid_q & ~ar_ready_i) |
                             ((ar_cnt_nx_c < num_q) & skew_ok_c);
                aw_valid_d = (aw_valid_q & ~aw_ready_i) | (aw_cnt_nx_c < num_q);
                // Counter is unchanged while stalled, so the address is too
                ar_addr_d  = src_base_q + (AddrWidth'(ar_cnt_nx_c) << LineShift);
                aw_addr_d  = dst_base_q + (AddrWidth'(aw_cnt_nx_c) << LineShift);
            end
            ST_DONE: begin
                ar_valid_d = 1'b0;
                aw_valid_d = 1'b0;
            end
            default: begin
                ar_valid_d = 1'b0;
                aw_valid_d = 1'b0;
            end
        endcase

        busy_d      = (state_d == ST_ISSUE);
        cmd_ready_d = (state_d == ST_IDLE);
        done_d      = (state_q == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_base_q  <= '0;
            dst_base_q  <= '0;
            num_q       <= '0;
            alloc_q     <= 1'b0;
            ar_cnt_q    <= '0;
            aw_cnt_q    <= '0;
            ar_valid_q  <= 1'b0;
            aw_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            aw_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            src_base_q  <= src_base_d;
            dst_base_q  <= dst_base_d;
            num_q       <= num_d;
            alloc_q     <= alloc_d;
            ar_cnt_q    <= ar_cnt_d;
            aw_cnt_q    <= aw_cnt_d;
            ar_valid_q  <= ar_valid_d;
            aw_valid_q  <= aw_valid_d;
            ar_addr_q   <= ar_addr_d;
            aw_addr_q   <= aw_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign ar_addr_o    = ar_addr_q;
    assign ar_id_o      = IdWidth'(AxiId);
    assign ar_size_o    = 3'(SizeVal);
    assign ar_src_dst_o = alloc_q;
    assign ar_valid_o   = ar_valid_q;
    assign aw_addr_o    = aw_addr_q;
    assign aw_id_o      = IdWidth'(AxiId);
    assign aw_size_o    = 3'(SizeVal);
    assign aw_src_dst_o = alloc_q;
    assign aw_valid_o   = aw_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
